// File: rtl/pdm_capture_ctrl_if.sv
// Sample stream between the capture controller and its downstream consumer.
//   m_data  : head-of-FIFO PCM sample
//   m_valid : head entry present
//   m_ready : consumer accepts the head this cycle
//   m_last  : head is the final sample of a finite session
// master = controller side, slave = consumer side.
interface pdm_capture_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/pdm_capture_ctrl.sv
// PDM capture session controller.
// Enables the PDM/CIC/FIR datapath, discards WARMUP_SAMPLES warm-up samples,
// then forwards cfg_len PCM samples (0 = continuous) through a small FIFO to a
// valid/ready consumer. Reports done / aborted pulses and sticky overflow.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, abort      : one-cycle control pulses
//   cfg_len           : samples to deliver, latched on accepted start
//   pcm_en            : datapath enable
//   pcm_in, pcm_ready : datapath sample and its ready level (0->1 = new sample)
//   m                 : output sample stream (master side)
//   busy, done, aborted, overflow, sample_cnt : status
module pdm_capture_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int LEN_WIDTH      = 16,
  parameter int WARMUP_SAMPLES = 32,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  pcm_en,
  input  logic [DATA_WIDTH-1:0] pcm_in,
  input  logic                  pcm_ready,
  pdm_capture_ctrl_if.master    m,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  overflow,
  output logic [LEN_WIDTH-1:0]  sample_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int WW = (WARMUP_SAMPLES > 0) ? $clog2(WARMUP_SAMPLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  ready_q;
  logic                  rise;
  logic [WW-1:0]         warm_cnt;
  logic [LEN_WIDTH-1:0]  len_q;

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic [PW-1:0]         wr_ptr, rd_ptr, occupancy;
  logic [AW-1:0]         wr_idx, rd_idx;

  logic empty, full, pop, push, drop, push_last;
  logic start_ok, abort_ok, warm_done, done_d;

  // ready_q follows pcm_ready in every state, so a level that is already high
  // when the session starts does not count as a new sample.
  assign rise = pcm_ready & ~ready_q;

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  assign m.m_valid = ~empty;
  assign m.m_data  = data_mem[rd_idx];
  assign m.m_last  = ~empty & last_mem[rd_idx];
  assign pop       = ~empty & m.m_ready;

  assign start_ok  = (state_q == IDLE) & start & ~abort;
  assign abort_ok  = (state_q != IDLE) & abort;
  assign warm_done = rise & ((warm_cnt + WW'(1)) == WW'(WARMUP_SAMPLES));

  // A sample arriving into a full FIFO is still accepted when the head is
  // leaving in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    push_last = 1'b0;
    if (state_q == CAPTURE && rise && !abort) begin
      if (!full || pop) begin
        push      = 1'b1;
        push_last = (len_q != '0) && ((sample_cnt + LEN_WIDTH'(1)) == len_q);
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = (WARMUP_SAMPLES == 0) ? CAPTURE : WARMUP;
      end
      WARMUP: begin
        if (abort)          state_d = IDLE;
        else if (warm_done) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (abort)          state_d = IDLE;
        else if (push_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (empty || (pop && occupancy == PW'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pcm_en = (state_q == WARMUP) || (state_q == CAPTURE);
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      warm_cnt   <= '0;
      len_q      <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_mem   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) data_mem[i] <= '0;
    end else begin
      ready_q <= pcm_ready;
      done    <= done_d;
      aborted <= abort_ok;

      if (start_ok) begin
        len_q      <= cfg_len;
        sample_cnt <= '0;
        overflow   <= 1'b0;
        warm_cnt   <= '0;
      end

      if (state_q == WARMUP && rise && !abort) warm_cnt <= warm_cnt + WW'(1);

      if (drop) overflow <= 1'b1;

      if (push) begin
        data_mem[wr_idx] <= pcm_in;
        last_mem[wr_idx] <= push_last;
        wr_ptr           <= wr_ptr + PW'(1);
        if (sample_cnt != '1) sample_cnt <= sample_cnt + LEN_WIDTH'(1);
      end

      if (pop) rd_ptr <= rd_ptr + PW'(1);

      // Flush takes priority over any same-cycle pointer movement.
      if (abort_ok) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Self-checking bench for pdm_capture_ctrl: directed scenarios plus randomized
// sessions, checked by a session-level reference model and an output scoreboard.
module tb_pdm_capture_ctrl;

  localparam int DW = 16;
  localparam int LW = 16;
  localparam int WU = 4;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [DW-1:0] pcm_in = '0;
  logic          pcm_ready = 1'b0;
  logic          pcm_en, busy, done, aborted, overflow;
  logic [LW-1:0] sample_cnt;

  pdm_capture_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

  pdm_capture_ctrl #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .WARMUP_SAMPLES(WU), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
    .pcm_en(pcm_en), .pcm_in(pcm_in), .pcm_ready(pcm_ready), .m(m_if),
    .busy(busy), .done(done), .aborted(aborted), .overflow(overflow),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    bit            last;
  } item_t;

  item_t       exp_q[$];
  bit          md_active, md_prev, md_ovf, md_done, md_ab;
  int          md_warm, md_occ;
  int unsigned md_len, md_cnt;
  bit          md_rise, md_pop, md_fin;
  item_t       md_item;

  // Session view: warm-up samples remaining, samples captured, FIFO occupancy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_active = 0; md_prev = 0; md_ovf = 0; md_done = 0; md_ab = 0;
      md_warm = 0; md_occ = 0; md_len = 0; md_cnt = 0;
      exp_q.delete();
    end else begin
      md_rise = pcm_ready && !md_prev;
      md_prev = pcm_ready;
      md_pop  = (md_occ > 0) && m_if.m_ready;
      md_fin  = (md_len != 0) && (md_cnt == md_len);
      md_done = 0;
      md_ab   = 0;
      if (!md_active) begin
        if (start && !abort) begin
          md_active = 1; md_warm = WU; md_len = cfg_len; md_cnt = 0; md_ovf = 0;
        end
      end else if (abort) begin
        md_active = 0; md_occ = 0; md_ab = 1;
        exp_q.delete();
      end else begin
        if (md_warm > 0) begin
          if (md_rise) md_warm--;
        end else if (!md_fin) begin
          if (md_rise) begin
            if (md_occ < FD || md_pop) begin
              md_occ++;
              if (md_cnt != (1 << LW) - 1) md_cnt++;
              md_item.d    = pcm_in;
              md_item.last = (md_len != 0) && (md_cnt == md_len);
              exp_q.push_back(md_item);
            end else begin
              md_ovf = 1;
            end
          end
        end
        if (md_pop) md_occ--;
        if (md_fin && md_occ == 0) begin
          md_done = 1; md_active = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("m_valid", m_if.m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("m_last", m_if.m_last, exp_q[0].last);
        if (m_if.m_valid) begin
          check("m_data", m_if.m_data, exp_q[0].d);
          if (m_if.m_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("m_last_idle", m_if.m_last, 0);
      end
      check("busy", busy, md_active);
      check("pcm_en", pcm_en, md_active && !((md_len != 0) && (md_cnt == md_len)));
      check("done", done, md_done);
      check("aborted", aborted, md_ab);
      check("overflow", overflow, md_ovf);
      check("sample_cnt", sample_cnt, md_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(input int len);
    start   = 1'b1;
    cfg_len = LW'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic sample(input logic [DW-1:0] d, input int gap);
    pcm_in    = d;
    pcm_ready = 1'b1;
    cyc();
    pcm_ready = 1'b0;
    cyc(gap);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check("wait_idle", busy, 0);
    if (busy === 1'b1) begin
      pulse_abort();
      cyc(2);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pcm_en"}, pcm_en, 0);
    check({tag, "_m_valid"}, m_if.m_valid, 0);
    check({tag, "_m_last"}, m_if.m_last, 0);
    check({tag, "_m_data"}, m_if.m_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_sample_cnt"}, sample_cnt, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.m_ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    #1;
    check_reset_vals("reset");
    cyc(2);

    // Basic session: 4 discarded, 3 delivered, last on 0x0007.
    m_if.m_ready = 1'b1;
    pulse_start(3);
    for (int i = 1; i <= 7; i++) sample(DW'(i), 2);
    wait_idle(50);
    cyc(3);

    // Backpressure overflow in continuous mode.
    m_if.m_ready = 1'b0;
    pulse_start(0);
    for (int i = 0; i < WU; i++) sample(16'h00F0, 1);
    for (int i = 0; i < 10; i++) sample(DW'(16'h0100 + i), 1);
    m_if.m_ready = 1'b1;
    cyc(12);
    pulse_abort();
    cyc(3);

    // Abort in CAPTURE with three entries queued.
    m_if.m_ready = 1'b0;
    pulse_start(0);
    for (int i = 0; i < WU; i++) sample(16'h0AAA, 1);
    for (int i = 0; i < 3; i++) sample(DW'(16'h0200 + i), 1);
    pulse_abort();
    cyc(3);
    m_if.m_ready = 1'b1;

    // start+abort in IDLE ignored; start while busy and cfg_len change ignored.
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    cyc(2);
    pulse_start(5);
    sample(16'h0301, 1);
    pulse_start(2);
    for (int i = 2; i <= 9; i++) sample(DW'(16'h0300 + i), 1);
    wait_idle(50);
    cyc(2);

    // pcm_ready already high at session start is not a sample.
    pcm_in    = 16'hAAAA;
    pcm_ready = 1'b1;
    cyc(2);
    pulse_start(2);
    cyc(2);
    pcm_ready = 1'b0;
    cyc();
    for (int i = 0; i < WU + 2; i++) sample(DW'(16'h0400 + i), 1);
    wait_idle(50);
    cyc(2);

    // Full FIFO with simultaneous pop and rise.
    m_if.m_ready = 1'b0;
    pulse_start(0);
    for (int i = 0; i < WU; i++) sample(16'h0BBB, 1);
    for (int i = 0; i < FD; i++) sample(DW'(16'h0500 + i), 1);
    m_if.m_ready = 1'b1;
    pcm_in       = 16'h05FF;
    pcm_ready    = 1'b1;
    cyc();
    m_if.m_ready = 1'b0;
    pcm_ready    = 1'b0;
    cyc(3);
    m_if.m_ready = 1'b1;
    cyc(12);
    pulse_abort();
    cyc(3);

    // Asynchronous reset while draining.
    m_if.m_ready = 1'b0;
    pulse_start(2);
    for (int i = 0; i < WU + 2; i++) sample(DW'(16'h0600 + i), 1);
    cyc(2);
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    cyc(2);
    rst = 1'b0;
    m_if.m_ready = 1'b1;
    cyc(2);

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      m_if.m_ready = 1'b1;
      pulse_start(int'($urandom_range(0, 12)));
      for (int c = 0; c < 200 && busy === 1'b1; c++) begin
        pcm_ready    = ($urandom_range(0, 2) == 0);
        pcm_in       = DW'($urandom);
        m_if.m_ready = ($urandom_range(0, 3) != 0);
        abort        = ($urandom_range(0, 150) == 0) || (c == 199);
        start        = ($urandom_range(0, 20) == 0);
        cfg_len      = LW'($urandom_range(0, 12));
        cyc();
      end
      abort        = 1'b0;
      start        = 1'b0;
      pcm_ready    = 1'b0;
      m_if.m_ready = 1'b1;
      cyc(2);
      if (busy === 1'b1) pulse_abort();
      cyc(3);
      check("rand_idle", busy, 0);
    end

    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
